axicb_slv_switch: RTL and testbench
===================================

# axicb_slv_switch

Routes one master-side AXI port to `SLV_NB` slave ports and merges slave responses back onto that single port. It is the slave-side counterpart of the crossbar's master switch: one instance sits per master on the path into the crossbar fabric. It decodes AW/AR addresses against per-slave ranges and tracks write-data ordering in a FIFO. It arbitrates B and R responses round-robin, holding the R grant for a whole burst.

## Interface
- `AXI_ADDR_W`, 16: address width.
- `AXI_ID_W`, 8: ID width.
- `SLV_NB`, 4: number of slaves, 1..4.
- `SLVn_START_ADDR` / `SLVn_END_ADDR` (n=0..3), n·0x1000 / n·0x1000+0xFFF: inclusive address range of slave n.
- `WR_FIFO_DEPTH`, 8: write-order FIFO entries, power of 2.
- `AWCH_W`, `WCH_W`, `BCH_W`, `ARCH_W`, `RCH_W`, 8: concatenated channel widths.
- Channel field packing:
  - AWCH/ARCH = {.., LEN[7:0], ADDR, ID}, with ID at LSBs.
  - BCH = {RESP[1:0], ID}.
  - RCH = {RESP[1:0], DATA, ID}.
- `aclk` in 1: clock.
- `areset` in 1: asynchronous active-high reset.
- `i_awvalid`/`i_awch` in, `i_awready` out: master AW.
- `i_wvalid`/`i_wlast`/`i_wch` in, `i_wready` out: master W.
- `i_bvalid`/`i_bch` out, `i_bready` in: master B.
- `i_arvalid`/`i_arch` in, `i_arready` out: master AR.
- `i_rvalid`/`i_rlast`/`i_rch` out, `i_rready` in: master R.
- `o_awvalid[SLV_NB]` out, `o_awready[SLV_NB]` in, `o_awch[AWCH_W]` out (broadcast).
- `o_wvalid[SLV_NB]` out, `o_wready[SLV_NB]` in, `o_wlast` / `o_wch[WCH_W]` out (broadcast).
- `o_bvalid[SLV_NB]` in, `o_bready[SLV_NB]` out, `o_bch[SLV_NB*BCH_W]` in.
- `o_arvalid[SLV_NB]` out, `o_arready[SLV_NB]` in, `o_arch[ARCH_W]` out (broadcast).
- `o_rvalid[SLV_NB]` in, `o_rready[SLV_NB]` out, `o_rlast[SLV_NB]` in, `o_rch[SLV_NB*RCH_W]` in.

## Operation
- **Address decode**
  - Combinational compare START ≤ ADDR ≤ END.
  - The lowest-index matching slave wins.
- **AW channel**
  - `o_awvalid[s] = i_awvalid & hit[s] & !fifo_full`.
  - `i_awready = o_awready[s] & !fifo_full`.
  - On AW handshake, push `s` into the write-order FIFO.
  - Push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
- **W channel**
  - The FIFO head selects the slave: `o_wvalid[head] = i_wvalid & !empty` and `i_wready = o_wready[head] & !empty`.
  - Pop on a W handshake with `i_wlast=1`.
  - While the FIFO is empty, `i_wready=0`.
- **B channel**
  - Round-robin over `o_bvalid`.
  - The grant is held while `i_bvalid & !i_bready`.
  - After a handshake the priority pointer moves to grant+1.
- **AR channel**
  - Decoded and routed like AW, with no FIFO.
- **R channel**
  - Round-robin over `o_rvalid`.
  - The grant locks at the first beat and releases after the handshake with `rlast=1`.
  - The pointer then moves to grant+1.
  - `o_rready` is asserted only to the granted slave.
- **Arbiter reset state:** pointers give slave 0 highest priority.

## Timing
- AW, AR, W and all ready paths are combinational (0-cycle).
- W for an AW is accepted at the earliest one cycle after the AW handshake (registered FIFO push).
- B/R arbitration is combinational on the current pointer; the grant is registered once valid is stalled.
- While `areset` is high, every valid/ready output is 0. At reset the FIFO is empty, the pointers are 0, and the R lock is clear.
- Reset mid-burst drops all state; no partial transfer completes.

## Configuration
- **`AXICB_DECERR_EN` defined:** an internal error slave with index `SLV_NB` handles unmapped addresses.
  - Unmapped AW is accepted and pushes index `SLV_NB` into the FIFO; its ID is stored.
  - W beats for it see `i_wready=1` and are discarded.
  - After `wlast`, an error-slave B request of {2'b11, ID} enters B arbitration.
  - Unmapped AR returns LEN+1 beats with RESP=2'b11, DATA=0 and `rlast` on the final beat, via R arbitration.
  - Only one unmapped write and one unmapped read may be outstanding; further unmapped AW/AR stall until they complete.
- **Undefined:** unmapped addresses route to slave `SLV_NB-1`.

## Test plan
- AW ADDR 0x1234 ID 0x05 followed by 4 W beats → only `o_awvalid[1]` and `o_wvalid[1]` are asserted; the FIFO is empty after `wlast`.
- 9 back-to-back AWs with `i_wvalid=0` and depth 8 → `i_awready=0` on the 9th AW until the first `wlast` pop.
- Slaves 0 and 2 assert `o_bvalid` simultaneously → B from slave 0 first, then slave 2; the pointer moves to 1 and then 3.
- Slave 1 sends an R burst of 4 beats while slave 3 raises `o_rvalid` at beat 2 → slave 3 is granted only after beat 4 (`rlast`).
- With `AXICB_DECERR_EN` defined, AR ADDR 0x8000 LEN 2 ID 0x07 → 3 R beats with RESP=2'b11, ID 0x07 and `rlast` on the 3rd beat; without the macro, the AR routes to slave 3.
- `areset` asserted during a W burst → all outputs are 0 immediately, and the FIFO is empty after release.

Source files
------------

// File: rtl/axicb_slv_switch.sv
// Slave-side crossbar switch: one master AXI port decoded onto SLV_NB slaves, B/R merged back.
// Define AXICB_DECERR_EN to add an internal error slave (index SLV_NB) for unmapped addresses.
module axicb_slv_switch #(
  parameter int          AXI_ADDR_W      = 16,
  parameter int          AXI_ID_W        = 8,
  parameter int          SLV_NB          = 4,
  parameter int unsigned SLV0_START_ADDR = 32'h0000,
  parameter int unsigned SLV0_END_ADDR   = 32'h0FFF,
  parameter int unsigned SLV1_START_ADDR = 32'h1000,
  parameter int unsigned SLV1_END_ADDR   = 32'h1FFF,
  parameter int unsigned SLV2_START_ADDR = 32'h2000,
  parameter int unsigned SLV2_END_ADDR   = 32'h2FFF,
  parameter int unsigned SLV3_START_ADDR = 32'h3000,
  parameter int unsigned SLV3_END_ADDR   = 32'h3FFF,
  parameter int          WR_FIFO_DEPTH   = 8,
  parameter int          AWCH_W          = 8,
  parameter int          WCH_W           = 8,
  parameter int          BCH_W           = 8,
  parameter int          ARCH_W          = 8,
  parameter int          RCH_W           = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     i_awvalid,
  output logic                     i_awready,
  input  logic [AWCH_W-1:0]        i_awch,
  input  logic                     i_wvalid,
  output logic                     i_wready,
  input  logic                     i_wlast,
  input  logic [WCH_W-1:0]         i_wch,
  output logic                     i_bvalid,
  input  logic                     i_bready,
  output logic [BCH_W-1:0]         i_bch,
  input  logic                     i_arvalid,
  output logic                     i_arready,
  input  logic [ARCH_W-1:0]        i_arch,
  output logic                     i_rvalid,
  input  logic                     i_rready,
  output logic                     i_rlast,
  output logic [RCH_W-1:0]         i_rch,
  output logic [SLV_NB-1:0]        o_awvalid,
  input  logic [SLV_NB-1:0]        o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic [SLV_NB-1:0]        o_wvalid,
  input  logic [SLV_NB-1:0]        o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic [SLV_NB-1:0]        o_bvalid,
  output logic [SLV_NB-1:0]        o_bready,
  input  logic [SLV_NB*BCH_W-1:0]  o_bch,
  output logic [SLV_NB-1:0]        o_arvalid,
  input  logic [SLV_NB-1:0]        o_arready,
  output logic [ARCH_W-1:0]        o_arch,
  input  logic [SLV_NB-1:0]        o_rvalid,
  output logic [SLV_NB-1:0]        o_rready,
  input  logic [SLV_NB-1:0]        o_rlast,
  input  logic [SLV_NB*RCH_W-1:0]  o_rch
);

`ifdef AXICB_DECERR_EN
  localparam int NB   = SLV_NB + 1;
  localparam int DFLT = SLV_NB;
`else
  localparam int NB   = SLV_NB;
  localparam int DFLT = SLV_NB - 1;
`endif
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW    = $clog2(WR_FIFO_DEPTH) + 1;

  localparam logic [AXI_ADDR_W-1:0] SLV_START [4] = '{
    AXI_ADDR_W'(SLV0_START_ADDR), AXI_ADDR_W'(SLV1_START_ADDR),
    AXI_ADDR_W'(SLV2_START_ADDR), AXI_ADDR_W'(SLV3_START_ADDR)};
  localparam logic [AXI_ADDR_W-1:0] SLV_END [4] = '{
    AXI_ADDR_W'(SLV0_END_ADDR), AXI_ADDR_W'(SLV1_END_ADDR),
    AXI_ADDR_W'(SLV2_END_ADDR), AXI_ADDR_W'(SLV3_END_ADDR)};

  // Range check via subtraction borrow; lowest matching index wins.
  function automatic logic [IDX_W-1:0] decode(input logic [AXI_ADDR_W-1:0] addr);
    logic [IDX_W-1:0]    d;
    logic [AXI_ADDR_W:0] dlo, dhi;
    d = IDX_W'(DFLT);
    for (int s = SLV_NB - 1; s >= 0; s--) begin
      dlo = {1'b0, addr} - {1'b0, SLV_START[s]};
      dhi = {1'b0, SLV_END[s]} - {1'b0, addr};
      if (!dlo[AXI_ADDR_W] && !dhi[AXI_ADDR_W]) d = IDX_W'(s);
    end
    return d;
  endfunction

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NB-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [NB-1:0]    rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;
    rot = NB'({req, req} >> ptr);
    off = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NB)) sum = sum - (IDX_W+1)'(NB);
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NB - 1)) ? '0 : g + 1'b1;
  endfunction

  logic run;
  assign run = ~areset;

  logic [IDX_W-1:0] aw_dst, ar_dst;
  assign aw_dst = decode(AXI_ADDR_W'(i_awch >> AXI_ID_W));
  assign ar_dst = decode(AXI_ADDR_W'(i_arch >> AXI_ID_W));

  assign o_awch  = i_awch;
  assign o_arch  = i_arch;
  assign o_wch   = i_wch;
  assign o_wlast = i_wlast;

  // Write-order FIFO: one entry per accepted AW, popped on the last W beat.
  logic [IDX_W-1:0] fifo_mem [WR_FIFO_DEPTH];
  logic [PW-1:0]    wp, rp;
  logic             fifo_full, fifo_empty, push, pop;
  logic [IDX_W-1:0] head;

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign head       = fifo_mem[rp[PW-2:0]];
  assign push       = i_awvalid & i_awready;
  assign pop        = i_wvalid & i_wready & i_wlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wp[PW-2:0]] <= aw_dst;
  end

  // Error slave state; constant-idle when the feature is compiled out.
  logic [NB-1:0] b_req, r_req;
`ifdef AXICB_DECERR_EN
  logic                err_w_busy, err_b_vld, err_r_busy;
  logic [AXI_ID_W-1:0] err_w_id, err_r_id;
  logic [7:0]          err_r_len, err_r_cnt;
  logic [BCH_W-1:0]    err_bch;
  logic [RCH_W-1:0]    err_rch;
  logic                err_rlast;

  assign b_req     = {err_b_vld, o_bvalid};
  assign r_req     = {err_r_busy, o_rvalid};
  assign err_bch   = BCH_W'(err_w_id) | (BCH_W'(2'b11) << (BCH_W - 2));
  assign err_rch   = RCH_W'(err_r_id) | (RCH_W'(2'b11) << (RCH_W - 2));
  assign err_rlast = (err_r_cnt == err_r_len);
`else
  assign b_req = o_bvalid;
  assign r_req = o_rvalid;
`endif

  // AW / AR routing
  logic aw_rdy, ar_rdy;
  always_comb begin
    o_awvalid = '0;
    aw_rdy    = 1'b0;
    for (int s = 0; s < SLV_NB; s++)
      if (aw_dst == IDX_W'(s)) begin
        o_awvalid[s] = i_awvalid & ~fifo_full & run;
        aw_rdy       = o_awready[s];
      end
`ifdef AXICB_DECERR_EN
    if (aw_dst == IDX_W'(SLV_NB)) aw_rdy = ~err_w_busy;
`endif
    i_awready = aw_rdy & ~fifo_full & run;
  end

  always_comb begin
    o_arvalid = '0;
    ar_rdy    = 1'b0;
    for (int s = 0; s < SLV_NB; s++)
      if (ar_dst == IDX_W'(s)) begin
        o_arvalid[s] = i_arvalid & run;
        ar_rdy       = o_arready[s];
      end
`ifdef AXICB_DECERR_EN
    if (ar_dst == IDX_W'(SLV_NB)) ar_rdy = ~err_r_busy;
`endif
    i_arready = ar_rdy & run;
  end

  // W follows the FIFO head
  logic w_rdy;
  always_comb begin
    o_wvalid = '0;
    w_rdy    = 1'b0;
    for (int s = 0; s < SLV_NB; s++)
      if (head == IDX_W'(s)) begin
        o_wvalid[s] = i_wvalid & ~fifo_empty & run;
        w_rdy       = o_wready[s];
      end
`ifdef AXICB_DECERR_EN
    if (head == IDX_W'(SLV_NB)) w_rdy = 1'b1;
`endif
    i_wready = w_rdy & ~fifo_empty & run;
  end

  // B arbitration: grant frozen while the master stalls a presented response
  logic [IDX_W-1:0] b_ptr, b_grant, b_grant_q;
  logic             b_hold;
  assign b_grant = b_hold ? b_grant_q : rr_pick(b_req, b_ptr);

  always_comb begin
    i_bvalid = 1'b0;
    i_bch    = '0;
    o_bready = '0;
    for (int s = 0; s < SLV_NB; s++)
      if (b_grant == IDX_W'(s)) begin
        i_bvalid    = o_bvalid[s];
        i_bch       = o_bch[s*BCH_W +: BCH_W];
        o_bready[s] = i_bready & run;
      end
`ifdef AXICB_DECERR_EN
    if (b_grant == IDX_W'(SLV_NB)) begin
      i_bvalid = err_b_vld;
      i_bch    = err_bch;
    end
`endif
    i_bvalid = i_bvalid & run;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      b_ptr     <= '0;
      b_hold    <= 1'b0;
      b_grant_q <= '0;
    end else begin
      b_hold    <= i_bvalid & ~i_bready;
      b_grant_q <= b_grant;
      if (i_bvalid & i_bready) b_ptr <= inc(b_grant);
    end
  end

  // R arbitration: grant locked from the first presented beat until the rlast handshake
  logic [IDX_W-1:0] r_ptr, r_grant, r_grant_q;
  logic             r_lock;
  assign r_grant = r_lock ? r_grant_q : rr_pick(r_req, r_ptr);

  always_comb begin
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rch    = '0;
    o_rready = '0;
    for (int s = 0; s < SLV_NB; s++)
      if (r_grant == IDX_W'(s)) begin
        i_rvalid    = o_rvalid[s];
        i_rlast     = o_rlast[s];
        i_rch       = o_rch[s*RCH_W +: RCH_W];
        o_rready[s] = i_rready & run;
      end
`ifdef AXICB_DECERR_EN
    if (r_grant == IDX_W'(SLV_NB)) begin
      i_rvalid = err_r_busy;
      i_rlast  = err_rlast;
      i_rch    = err_rch;
    end
`endif
    i_rvalid = i_rvalid & run;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_grant_q <= '0;
    end else begin
      r_grant_q <= r_grant;
      if (i_rvalid & i_rready & i_rlast) begin
        r_lock <= 1'b0;
        r_ptr  <= inc(r_grant);
      end else if (i_rvalid) begin
        r_lock <= 1'b1;
      end
    end
  end

`ifdef AXICB_DECERR_EN
  // One outstanding unmapped write and one unmapped read at a time
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_w_busy <= 1'b0;
      err_b_vld  <= 1'b0;
      err_w_id   <= '0;
      err_r_busy <= 1'b0;
      err_r_id   <= '0;
      err_r_len  <= '0;
      err_r_cnt  <= '0;
    end else begin
      if (push && aw_dst == IDX_W'(SLV_NB)) begin
        err_w_busy <= 1'b1;
        err_w_id   <= AXI_ID_W'(i_awch);
      end
      if (pop && head == IDX_W'(SLV_NB)) err_b_vld <= 1'b1;
      if (i_bvalid && i_bready && b_grant == IDX_W'(SLV_NB)) begin
        err_b_vld  <= 1'b0;
        err_w_busy <= 1'b0;
      end
      if (i_arvalid && i_arready && ar_dst == IDX_W'(SLV_NB)) begin
        err_r_busy <= 1'b1;
        err_r_id   <= AXI_ID_W'(i_arch);
        err_r_len  <= 8'(i_arch >> (AXI_ID_W + AXI_ADDR_W));
        err_r_cnt  <= '0;
      end else if (i_rvalid && i_rready && r_grant == IDX_W'(SLV_NB)) begin
        if (err_rlast) err_r_busy <= 1'b0;
        else           err_r_cnt  <= err_r_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axicb_slv_switch.sv
// Directed self-checking bench for axicb_slv_switch (4 slaves, 16-bit address, 8-bit ID).
module tb_axicb_slv_switch;
  localparam int AW_W = 32;
  localparam int B_W  = 10;
  localparam int R_W  = 18;

  logic aclk = 1'b0;
  logic areset;
  logic i_awvalid, i_awready, i_wvalid, i_wready, i_wlast;
  logic i_bvalid, i_bready, i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [AW_W-1:0] i_awch, i_arch, o_awch, o_arch;
  logic [7:0]      i_wch, o_wch;
  logic [B_W-1:0]  i_bch;
  logic [R_W-1:0]  i_rch;
  logic [3:0] o_awvalid, o_awready, o_wvalid, o_wready, o_bvalid, o_bready;
  logic [3:0] o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;
  logic       o_wlast;
  logic [4*B_W-1:0] o_bch;
  logic [4*R_W-1:0] o_rch;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axicb_slv_switch #(
    .AWCH_W(AW_W), .ARCH_W(AW_W), .WCH_W(8), .BCH_W(B_W), .RCH_W(R_W)
  ) dut (
    .aclk(aclk), .areset(areset),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] ach(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id);
    return {len, addr, id};
  endfunction

  logic [15:0] dec_addr [6] = '{16'h0000, 16'h0FFF, 16'h1000, 16'h1234, 16'h3FFF, 16'h4000};
`ifdef AXICB_DECERR_EN
  logic [3:0]  dec_exp  [6] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h8, 4'h0};
`else
  logic [3:0]  dec_exp  [6] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h8, 4'h8};
`endif

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input driven active: outputs must stay quiet
    areset = 1'b1;
    i_awvalid = 1'b1; i_awch = ach(16'h1234, 8'd0, 8'h05);
    i_wvalid = 1'b1; i_wlast = 1'b1; i_wch = 8'h00;
    i_bready = 1'b1; i_arvalid = 1'b1; i_arch = ach(16'h2000, 8'd0, 8'h01); i_rready = 1'b1;
    o_awready = 4'hF; o_wready = 4'hF; o_bvalid = 4'hF; o_arready = 4'hF;
    o_rvalid = 4'hF; o_rlast = 4'h0;
    o_bch = {10'h3A3, 10'h2A2, 10'h1A1, 10'h0A0};
    for (int s = 0; s < 4; s++) o_rch[s*R_W +: R_W] = R_W'(s * 256 + 16 + s);
    #3;
    chk("rst_o_awvalid", 32'(o_awvalid), 32'h0);
    chk("rst_i_awready", 32'(i_awready), 32'h0);
    chk("rst_i_wready",  32'(i_wready),  32'h0);
    chk("rst_o_wvalid",  32'(o_wvalid),  32'h0);
    chk("rst_i_bvalid",  32'(i_bvalid),  32'h0);
    chk("rst_o_bready",  32'(o_bready),  32'h0);
    chk("rst_o_arvalid", 32'(o_arvalid), 32'h0);
    chk("rst_i_arready", 32'(i_arready), 32'h0);
    chk("rst_i_rvalid",  32'(i_rvalid),  32'h0);
    chk("rst_o_rready",  32'(o_rready),  32'h0);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
    o_bvalid = 4'h0; o_rvalid = 4'h0;
    tick(); tick();
    areset = 1'b0;
    tick();

    // Address decode boundaries (slaves not ready, so nothing is accepted)
    o_awready = 4'h0;
    i_awvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_awch = ach(dec_addr[k], 8'd0, 8'h01);
      #1 chk($sformatf("decode_%h", dec_addr[k]), 32'(o_awvalid), 32'(dec_exp[k]));
    end
    i_awvalid = 1'b0;

    // AW 0x1234 ID 5 then 4 W beats to slave 1
    o_awready = 4'hF; o_wready = 4'hF;
    i_awvalid = 1'b1; i_awch = ach(16'h1234, 8'd3, 8'h05);
    i_wvalid = 1'b1; i_wlast = 1'b0; i_wch = 8'hC0;
    #1;
    chk("aw1_o_awvalid", 32'(o_awvalid), 32'h2);
    chk("aw1_i_awready", 32'(i_awready), 32'h1);
    chk("aw1_o_awch",    o_awch,         32'h03123405);
    chk("w_before_push_i_wready", 32'(i_wready), 32'h0);
    chk("w_before_push_o_wvalid", 32'(o_wvalid), 32'h0);
    tick();
    i_awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_wlast = (b == 3);
      i_wch   = 8'(8'hC0 + b);
      #1;
      chk($sformatf("w1_beat%0d_o_wvalid", b), 32'(o_wvalid), 32'h2);
      chk($sformatf("w1_beat%0d_i_wready", b), 32'(i_wready), 32'h1);
      chk($sformatf("w1_beat%0d_o_wch", b),    32'(o_wch),    32'(8'hC0 + b));
      tick();
    end
    #1 chk("w1_empty_i_wready", 32'(i_wready), 32'h0);
    chk("w1_empty_o_wvalid", 32'(o_wvalid), 32'h0);
    i_wvalid = 1'b0; i_wlast = 1'b0;

    // Fill the 8-entry FIFO, 9th AW must stall until a wlast pop retires
    i_awvalid = 1'b1; i_awch = ach(16'h2000, 8'd0, 8'h01);
    for (int j = 0; j < 8; j++) begin
      #1 chk($sformatf("fill%0d_i_awready", j), 32'(i_awready), 32'h1);
      tick();
    end
    #1;
    chk("full_i_awready", 32'(i_awready), 32'h0);
    chk("full_o_awvalid", 32'(o_awvalid), 32'h0);
    i_wvalid = 1'b1; i_wlast = 1'b1;
    #1;
    chk("full_pop_cycle_i_awready", 32'(i_awready), 32'h0);
    chk("full_pop_o_wvalid", 32'(o_wvalid), 32'h4);
    tick();
    #1 chk("after_pop_i_awready", 32'(i_awready), 32'h1);
    tick();
    i_awvalid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      #1 chk($sformatf("drain%0d_i_wready", j), 32'(i_wready), 32'h1);
      tick();
    end
    #1 chk("drained_i_wready", 32'(i_wready), 32'h0);
    i_wvalid = 1'b0; i_wlast = 1'b0;

    // B round-robin: slaves 0 and 2 together
    i_bready = 1'b1; o_bvalid = 4'b0101;
    #1;
    chk("b0_i_bvalid", 32'(i_bvalid), 32'h1);
    chk("b0_i_bch",    32'(i_bch),    32'h0A0);
    chk("b0_o_bready", 32'(o_bready), 32'h1);
    tick();
    o_bvalid = 4'b0100;
    #1;
    chk("b2_i_bch",    32'(i_bch),    32'h2A2);
    chk("b2_o_bready", 32'(o_bready), 32'h4);
    tick();
    // Pointer now 3: stall slave 0 then raise slave 3, grant must hold on slave 0
    o_bvalid = 4'b0001; i_bready = 1'b0;
    #1 chk("bhold_first_i_bch", 32'(i_bch), 32'h0A0);
    tick();
    o_bvalid = 4'b1001;
    #1 chk("bhold_i_bch", 32'(i_bch), 32'h0A0);
    i_bready = 1'b1;
    #1 chk("bhold_o_bready", 32'(o_bready), 32'h1);
    tick();
    #1 chk("b_after_hold_i_bch", 32'(i_bch), 32'h3A3);
    tick();
    o_bvalid = 4'b0000;

    // R burst from slave 1; slave 3 joins at beat 2 and waits for rlast
    i_rready = 1'b1; o_rvalid = 4'b0010; o_rlast = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin o_rvalid = 4'b1010; o_rlast = 4'b1000; end
      if (b == 3) o_rlast = 4'b1010;
      #1;
      chk($sformatf("r1_beat%0d_o_rready", b), 32'(o_rready), 32'h2);
      chk($sformatf("r1_beat%0d_i_rch", b),    32'(i_rch),    32'h00111);
      chk($sformatf("r1_beat%0d_i_rlast", b),  32'(i_rlast),  32'(b == 3));
      tick();
    end
    o_rvalid = 4'b1000; o_rlast = 4'b1000;
    #1;
    chk("r3_o_rready", 32'(o_rready), 32'h8);
    chk("r3_i_rch",    32'(i_rch),    32'h00313);
    tick();
    // Slave 2 two-beat burst; slave 0 (higher priority now) arrives mid-burst
    o_rvalid = 4'b0100; o_rlast = 4'b0000;
    #1 chk("r2_beat0_o_rready", 32'(o_rready), 32'h4);
    tick();
    o_rvalid = 4'b0101; o_rlast = 4'b0101;
    #1 chk("r2_lock_o_rready", 32'(o_rready), 32'h4);
    tick();
    o_rvalid = 4'b0001;
    #1 chk("r0_after_lock_o_rready", 32'(o_rready), 32'h1);
    tick();
    o_rvalid = 4'b0000; o_rlast = 4'b0000;

    // AR to unmapped 0x8000 LEN 2 ID 7
    o_arready = 4'b1000;
    i_arvalid = 1'b1; i_arch = ach(16'h8000, 8'd2, 8'h07);
`ifdef AXICB_DECERR_EN
    #1;
    chk("ar_err_o_arvalid", 32'(o_arvalid), 32'h0);
    chk("ar_err_i_arready", 32'(i_arready), 32'h1);
    tick();
    i_arvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk($sformatf("rerr_beat%0d_i_rvalid", b), 32'(i_rvalid), 32'h1);
      chk($sformatf("rerr_beat%0d_i_rch", b),    32'(i_rch),    32'h30007);
      chk($sformatf("rerr_beat%0d_i_rlast", b),  32'(i_rlast),  32'(b == 2));
      tick();
    end
    #1 chk("rerr_done_i_rvalid", 32'(i_rvalid), 32'h0);
`else
    #1;
    chk("ar_unmapped_o_arvalid", 32'(o_arvalid), 32'h8);
    chk("ar_unmapped_i_arready", 32'(i_arready), 32'h1);
    o_arready = 4'b0111;
    #1 chk("ar_unmapped_notready", 32'(i_arready), 32'h0);
`endif
    i_arch = ach(16'h2345, 8'd0, 8'h02); o_arready = 4'b0000;
    #1 chk("ar_2345_o_arvalid", 32'(o_arvalid), 32'h4);
    i_arvalid = 1'b0;

    // Reset in the middle of a W burst
    tick();
    o_awready = 4'hF; o_wready = 4'hF;
    i_awvalid = 1'b1; i_awch = ach(16'h0100, 8'd1, 8'h01);
    tick();
    i_awvalid = 1'b0; i_wvalid = 1'b1; i_wlast = 1'b0;
    #1 chk("mid_o_wvalid", 32'(o_wvalid), 32'h1);
    tick();
    areset = 1'b1;
    #1;
    chk("mid_rst_o_wvalid", 32'(o_wvalid), 32'h0);
    chk("mid_rst_i_wready", 32'(i_wready), 32'h0);
    tick();
    areset = 1'b0;
    i_wlast = 1'b1;
    #1;
    chk("post_rst_i_wready", 32'(i_wready), 32'h0);
    chk("post_rst_o_wvalid", 32'(o_wvalid), 32'h0);
    i_wvalid = 1'b0; i_wlast = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
